// File: rtl/dpsram_pkg.sv
// Shared types and helpers for the parameterised dual-port SRAM.
package dpsram_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  // Widest supported word; parity is computed on a zero-extended copy.
  localparam int PAR_MAX_W = 36;

  function automatic int rd_latency(input int out_reg);
    return 1 + out_reg;
  endfunction

  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/dpsram_port_pipe.sv
// Read-data staging for one port: DOUT/DVLD/PERR with optional extra register.
module dpsram_port_pipe
  import dpsram_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int OUT_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vld_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              perr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dvld_o,
  output logic              perr_o
);

  logic              s1_vld_q;
  logic              s1_perr_q;
  logic [DATA_W-1:0] s1_data_q;

  // First stage: data only advances on a completed read so DOUT holds otherwise.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld_q  <= 1'b0;
      s1_perr_q <= 1'b0;
      s1_data_q <= '0;
    end else begin
      s1_vld_q  <= vld_i;
      s1_perr_q <= vld_i & perr_i;
      if (vld_i) begin
        s1_data_q <= data_i;
      end
    end
  end

  generate
    if (rd_latency(OUT_REG) > 1) begin : g_out_reg
      logic              s2_vld_q;
      logic              s2_perr_q;
      logic [DATA_W-1:0] s2_data_q;

      // Optional output stage, same hold behaviour as the first stage.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          s2_vld_q  <= 1'b0;
          s2_perr_q <= 1'b0;
          s2_data_q <= '0;
        end else begin
          s2_vld_q  <= s1_vld_q;
          s2_perr_q <= s1_perr_q;
          if (s1_vld_q) begin
            s2_data_q <= s1_data_q;
          end
        end
      end

      assign dout_o = s2_data_q;
      assign dvld_o = s2_vld_q;
      assign perr_o = s2_perr_q;
    end else begin : g_no_out_reg
      assign dout_o = s1_data_q;
      assign dvld_o = s1_vld_q;
      assign perr_o = s1_perr_q;
    end
  endgenerate

endmodule

// File: rtl/dpsram_param.sv
// True dual-port SRAM with self-clearing after reset, read-first ports and collision flag.
// Optional per-word even parity enabled by defining DPSRAM_PARITY_EN.
module dpsram_param
  import dpsram_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                ADDR_W   = 12,
  parameter int                OUT_REG  = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [ADDR_W-1:0] A_ADDR,
  input  logic [DATA_W-1:0] A_DIN,
  input  logic              A_WEN,
  input  logic              A_REN,
  output logic [DATA_W-1:0] A_DOUT,
  output logic              A_DVLD,
  output logic              A_PERR,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_DIN,
  input  logic              B_WEN,
  input  logic              B_REN,
  output logic [DATA_W-1:0] B_DOUT,
  output logic              B_DVLD,
  output logic              B_PERR,
  output logic              BUSY,
  output logic              COLL
);

  localparam int DEPTH = 1 << ADDR_W;
`ifdef DPSRAM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W-1:0] CNT_MAX = '1;

  logic [MEM_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we_s;
  logic              ready_s;
  logic              a_rd_s, a_wr_s, b_rd_s, b_wr_s;
  logic              a_we_s;
  logic [ADDR_W-1:0] a_waddr_s;
  logic [DATA_W-1:0] a_wdata_s;
  logic [MEM_W-1:0]  a_word_s, b_word_s;
  logic [MEM_W-1:0]  a_ram_q, b_ram_q;
  logic              a_rvld_q, b_rvld_q;
  logic              a_perr_s, b_perr_s;
  logic              coll_q, coll_d;

  // Clear sequencer: state and address counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: sweep every address once, then hand over to the user ports.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clr_we_s = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we_s = ~RST;
        cnt_d    = cnt_q + ADDR_W'(1);
        if (cnt_q == CNT_MAX) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_d = ST_READY;
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  assign BUSY    = (state_q == ST_CLEAR);
  assign ready_s = (state_q == ST_READY) & ~RST;
  assign a_rd_s  = ready_s & A_REN;
  assign a_wr_s  = ready_s & A_WEN;
  assign b_rd_s  = ready_s & B_REN;
  assign b_wr_s  = ready_s & B_WEN;

  // The clear sweep borrows port A; user ports are idle then.
  assign a_we_s    = clr_we_s | a_wr_s;
  assign a_waddr_s = clr_we_s ? cnt_q : A_ADDR;
  assign a_wdata_s = clr_we_s ? INIT_VAL : A_DIN;

`ifdef DPSRAM_PARITY_EN
  assign a_word_s = {even_parity(PAR_MAX_W'(a_wdata_s)), a_wdata_s};
  assign b_word_s = {even_parity(PAR_MAX_W'(B_DIN)), B_DIN};
  assign a_perr_s = even_parity(PAR_MAX_W'(a_ram_q[DATA_W-1:0])) ^ a_ram_q[DATA_W];
  assign b_perr_s = even_parity(PAR_MAX_W'(b_ram_q[DATA_W-1:0])) ^ b_ram_q[DATA_W];
`else
  assign a_word_s = a_wdata_s;
  assign b_word_s = B_DIN;
  assign a_perr_s = 1'b0;
  assign b_perr_s = 1'b0;
`endif

  // Array writes; port A is written last so it wins a same-address conflict.
  always_ff @(posedge CLK) begin
    if (b_wr_s) begin
      mem[B_ADDR] <= b_word_s;
    end
    if (a_we_s) begin
      mem[a_waddr_s] <= a_word_s;
    end
  end

  // Array read registers sample the pre-write contents (read-first).
  always_ff @(posedge CLK) begin
    if (a_rd_s) begin
      a_ram_q <= mem[A_ADDR];
    end
    if (b_rd_s) begin
      b_ram_q <= mem[B_ADDR];
    end
  end

  // Read-valid tags follow the array read registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_rvld_q <= 1'b0;
      b_rvld_q <= 1'b0;
    end else begin
      a_rvld_q <= a_rd_s;
      b_rvld_q <= b_rd_s;
    end
  end

  assign coll_d = (A_ADDR == B_ADDR) & (a_rd_s | a_wr_s) & (b_rd_s | b_wr_s) & (a_wr_s | b_wr_s);

  // Collision flag register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      coll_q <= 1'b0;
    end else begin
      coll_q <= coll_d;
    end
  end

  assign COLL = coll_q;

  dpsram_port_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_a (
    .clk_i  (CLK),
    .rst_i  (RST),
    .vld_i  (a_rvld_q),
    .data_i (a_ram_q[DATA_W-1:0]),
    .perr_i (a_perr_s),
    .dout_o (A_DOUT),
    .dvld_o (A_DVLD),
    .perr_o (A_PERR)
  );

  dpsram_port_pipe #(
    .DATA_W  (DATA_W),
    .OUT_REG (OUT_REG)
  ) u_pipe_b (
    .clk_i  (CLK),
    .rst_i  (RST),
    .vld_i  (b_rvld_q),
    .data_i (b_ram_q[DATA_W-1:0]),
    .perr_i (b_perr_s),
    .dout_o (B_DOUT),
    .dvld_o (B_DVLD),
    .perr_o (B_PERR)
  );

endmodule
